// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU.
// Produces {remainder, quotient} for the HI/LO writeback path and stalls the pipeline while busy.
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  signed_div,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    input  logic                  annul,
    output logic                  stall,
    output logic                  ready,
    output logic [2*DATA_W-1:0]   result
);
    localparam int CW = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state, state_nxt;
    logic [CW-1:0]       count;
    logic [DATA_W-1:0]   rem, quo, dvsr;
    logic                sign_q, sign_r;

    logic                neg_a, neg_b;
    logic [DATA_W-1:0]   a_mag, b_mag;
    logic [DATA_W:0]     shifted, diff;
    logic [DATA_W-1:0]   rem_nxt, quo_nxt, q_fix, r_fix;
    logic                last;
    logic                go;

    // Two's-complement negate gives the exact unsigned magnitude, including the most negative value.
    assign neg_a = signed_div & a[DATA_W-1];
    assign neg_b = signed_div & b[DATA_W-1];
    assign a_mag = neg_a ? -a : a;
    assign b_mag = neg_b ? -b : b;

    assign go   = (state == IDLE) & start & ~annul;
    assign last = (count == CW'(DATA_W-1));

    // One restoring step: bring in the next dividend bit, keep the difference if non-negative.
    always_comb begin
        shifted = {rem, quo[DATA_W-1]};
        diff    = shifted - {1'b0, dvsr};
        if (!diff[DATA_W]) begin
            rem_nxt = diff[DATA_W-1:0];
            quo_nxt = {quo[DATA_W-2:0], 1'b1};
        end else begin
            rem_nxt = shifted[DATA_W-1:0];
            quo_nxt = {quo[DATA_W-2:0], 1'b0};
        end
        q_fix = sign_q ? -quo_nxt : quo_nxt;
        r_fix = sign_r ? -rem_nxt : rem_nxt;
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        ready     = 1'b0;
        case (state)
            IDLE: begin
                stall = go;
                if (go) state_nxt = (b == '0) ? DONE : CALC;
            end
            CALC: begin
                stall = 1'b1;
                if (annul)     state_nxt = IDLE;
                else if (last) state_nxt = DONE;
            end
            DONE: begin
                ready     = ~annul;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            count  <= '0;
            rem    <= '0;
            quo    <= '0;
            dvsr   <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            result <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (go) begin
                    if (b == '0) begin
                        result <= {a, {DATA_W{1'b1}}};
                    end else begin
                        rem    <= '0;
                        quo    <= a_mag;
                        dvsr   <= b_mag;
                        sign_q <= neg_a ^ neg_b;
                        sign_r <= neg_a;
                        count  <= '0;
                    end
                end
                CALC: if (!annul) begin
                    rem   <= rem_nxt;
                    quo   <= quo_nxt;
                    count <= count + 1'b1;
                    if (last) result <= {r_fix, q_fix};
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected {HI,LO} and ready cycle, monitor pops on ready.
module tb_div_unit;
    logic        clk, rst_n, start, signed_div, annul;
    logic [31:0] a, b;
    logic        stall, ready;
    logic [63:0] result;

    typedef struct {
        logic [63:0] res;
        int          due;
    } exp_t;

    exp_t        q[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    logic [63:0] last_res = '0;

    div_unit #(.DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_div(signed_div),
        .a(a), .b(b), .annul(annul), .stall(stall), .ready(ready), .result(result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV '/' truncates toward zero and '%' follows the dividend.
    function automatic logic [63:0] ref_div(input bit sd, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy, qq, rr;
        logic [63:0] ux, uy, uq, ur;
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (sd) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            qq = sx / sy;
            rr = sx % sy;
            return {rr[31:0], qq[31:0]};
        end
        ux = {32'b0, x};
        uy = {32'b0, y};
        uq = ux / uy;
        ur = ux % uy;
        return {ur[31:0], uq[31:0]};
    endfunction

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && ready) begin
            if (q.size() == 0) begin
                check("unexpected_ready", 64'(ready), 64'(0));
            end else begin
                e = q.pop_front();
                check("result", result, e.res);
                check("ready_cycle", 64'(cyc), 64'(e.due));
                check("stall_in_ready", 64'(stall), 64'(0));
                last_res = e.res;
            end
        end
    end

    task automatic wait_drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (q.size() != 0) begin
            check("ready_timeout", 64'(q.size()), 64'(0));
            q.delete();
        end
        @(posedge clk); #1;
    endtask

    // Called just after a rising edge; E0 is the next edge.
    task automatic issue(input bit sd, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        start = 1'b1; signed_div = sd; a = x; b = y;
        #1 check("stall_on_start", 64'(stall), 64'(1));
        e.res = ref_div(sd, x, y);
        e.due = cyc + ((y == 0) ? 1 : 33);
        q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom; signed_div = 1'($urandom);
        wait_drain();
    endtask

    task automatic quiet(input int n, input string nm);
        repeat (n) begin @(posedge clk); #1; end
        check(nm, result, last_res);
    endtask

    initial begin
        logic [31:0] x, y;
        exp_t        e;
        rst_n = 1'b0; start = 1'b0; signed_div = 1'b0; annul = 1'b0; a = '0; b = '0;
        #12;
        check("rst_stall", 64'(stall), 64'(0));
        check("rst_ready", 64'(ready), 64'(0));
        check("rst_result", result, 64'(0));
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        issue(1'b0, 32'd100, 32'd7);
        check("t1_result", last_res, {32'd2, 32'd14});
        issue(1'b1, 32'hFFFF_FFF9, 32'd2);
        issue(1'b1, 32'd7, 32'hFFFF_FFFE);
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        check("t3_overflow", last_res, {32'd0, 32'h8000_0000});
        issue(1'b0, 32'hFFFF_FFFF, 32'd1);
        issue(1'b0, 32'h1234, 32'd0);
        check("t4_divzero", last_res, {32'h1234, 32'hFFFF_FFFF});
        issue(1'b1, 32'h8000_0000, 32'd1);
        issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(1'b1, 32'd5, 32'd9);

        // Annul mid-calculation at E10
        start = 1'b1; signed_div = 1'b0; a = 32'd9; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        annul = 1'b1;
        #1 check("annul_stall_before", 64'(stall), 64'(1));
        @(posedge clk); #1;
        annul = 1'b0;
        check("annul_stall_after", 64'(stall), 64'(0));
        quiet(40, "annul_result_kept");
        issue(1'b0, 32'd9, 32'd3);
        check("t5_restart", last_res, {32'd0, 32'd3});

        // start with annul in IDLE is ignored
        start = 1'b1; annul = 1'b1; a = 32'd50; b = 32'd5;
        #1 check("annul_idle_stall", 64'(stall), 64'(0));
        @(posedge clk); #1;
        start = 1'b0; annul = 1'b0;
        quiet(40, "annul_idle_result");

        // start held during CALC with changing operands: exactly one result
        start = 1'b1; signed_div = 1'b1; a = 32'hFFFF_FF00; b = 32'd7;
        e.res = ref_div(1'b1, 32'hFFFF_FF00, 32'd7);
        e.due = cyc + 33;
        q.push_back(e);
        repeat (30) begin
            @(posedge clk); #1;
            a = $urandom; b = $urandom; signed_div = 1'($urandom);
        end
        start = 1'b0;
        wait_drain();
        quiet(10, "held_start_single");

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            x = $urandom; y = $urandom;
            case ($urandom_range(0, 7))
                0: y = 32'd0;
                1: x = 32'h8000_0000;
                2: y = $urandom_range(1, 15);
                3: y = 32'hFFFF_FFFF;
                4: y = -$urandom_range(1, 15);
                default: ;
            endcase
            issue(1'($urandom), x, y);
        end

        // Asynchronous reset mid-CALC
        start = 1'b1; signed_div = 1'b0; a = 32'd1000; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        check("arst_stall", 64'(stall), 64'(0));
        check("arst_ready", 64'(ready), 64'(0));
        check("arst_result", result, 64'(0));
        last_res = '0;
        #3 rst_n = 1'b1;
        quiet(40, "arst_no_ready");
        issue(1'b1, 32'hFFFF_FFF9, 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
